// File: rtl/hmr_lockstep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hmr_lockstep_ctrl
// Description : Hybrid modular redundancy controller. Runs the cores in
//               independent, DMR (cores 0/1) or TMR (cores 0/1/2) mode. It
//               checks and votes the per-core output words combinationally,
//               and a halt/drain/resync/release controller recovers the
//               cores after a detected fault. It also keeps saturating
//               per-core fault counters and a sticky fatal state.
// Revision    : 1.0 - initial release
// ============================================================================
module hmr_lockstep_ctrl #(
    parameter int unsigned NumCores     = 3,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned ErrCntWidth  = 8,
    parameter int unsigned ResyncCycles = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [1:0]                             mode_i,
    input  logic                                   mode_valid_i,
    output logic                                   mode_ready_o,
    output logic [1:0]                             mode_o,
    input  logic [NumCores-1:0][DataWidth-1:0]     core_data_i,
    input  logic [NumCores-1:0]                    core_valid_i,
    input  logic [NumCores-1:0]                    core_idle_i,
    output logic [NumCores-1:0][DataWidth-1:0]     sys_data_o,
    output logic [NumCores-1:0]                    sys_valid_o,
    output logic [NumCores-1:0]                    halt_o,
    output logic [NumCores-1:0]                    resync_o,
    input  logic                                   clear_i,
    output logic [NumCores-1:0]                    fault_core_o,
    output logic [NumCores-1:0][ErrCntWidth-1:0]   err_cnt_o,
    output logic                                   fatal_o
);

    localparam logic [1:0] C_MODE_IND = 2'd0;
    localparam logic [1:0] C_MODE_DMR = 2'd1;
    localparam logic [1:0] C_MODE_TMR = 2'd2;
    localparam int unsigned C_RCW = (ResyncCycles > 1) ? $clog2(ResyncCycles) : 1;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_RESYNC  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FATAL   = 3'd4
    } state_t;

    state_t                          r_state;
    logic [1:0]                      r_mode;
    logic [NumCores-1:0]             r_halt;
    logic [NumCores-1:0]             r_resync;
    logic                            r_fatal;
    logic [C_RCW-1:0]                r_rcnt;
    logic [NumCores-1:0]             r_fault;

    // Three-wide views so the checking logic reads the same for 2 or 3 cores
    logic [2:0][DataWidth-1:0]       w_data3;
    logic [2:0]                      w_valid3;
    logic [2:0][DataWidth:0]         w_word;
    logic [DataWidth:0]              w_maj;
    logic [2:0][DataWidth-1:0]       w_sys_data3;
    logic [2:0]                      w_sys_valid3;
    logic [2:0]                      w_inc3;
    logic [2:0]                      w_flt3;
    logic                            w_fault_evt;
    logic                            w_fatal_evt;
    logic                            w_ab, w_ac, w_bc;
    logic [NumCores-1:0]             w_part;
    logic                            w_part_idle;
    logic                            w_mode_legal;

    generate
        if (NumCores == 3) begin : g_three
            assign w_data3  = core_data_i;
            assign w_valid3 = core_valid_i;
        end else begin : g_two
            assign w_data3  = {{DataWidth{1'b0}}, core_data_i};
            assign w_valid3 = {1'b0, core_valid_i};
        end
    endgenerate

    assign w_word[0] = {w_valid3[0], w_data3[0]};
    assign w_word[1] = {w_valid3[1], w_data3[1]};
    assign w_word[2] = {w_valid3[2], w_data3[2]};
    assign w_ab  = (w_word[0] == w_word[1]);
    assign w_ac  = (w_word[0] == w_word[2]);
    assign w_bc  = (w_word[1] == w_word[2]);
    assign w_maj = (w_word[0] & w_word[1]) | (w_word[0] & w_word[2]) | (w_word[1] & w_word[2]);

    // Check/vote datapath and fault classification for the current mode
    always_comb begin
        w_sys_data3  = w_data3;
        w_sys_valid3 = w_valid3;
        w_inc3       = 3'b000;
        w_flt3       = 3'b000;
        w_fault_evt  = 1'b0;
        w_fatal_evt  = 1'b0;
        case (r_mode)
            C_MODE_DMR: begin
                w_sys_valid3[0] = w_valid3[0] & w_ab;
                w_sys_data3[1]  = '0;
                w_sys_valid3[1] = 1'b0;
                if (!w_ab) begin
                    // A two-way mismatch cannot say which core is wrong
                    w_inc3[1:0] = 2'b11;
                    w_fault_evt = 1'b1;
                end
            end
            C_MODE_TMR: begin
                w_sys_data3[0]  = w_maj[DataWidth-1:0];
                w_sys_valid3[0] = w_maj[DataWidth] & (w_ab | w_ac | w_bc);
                w_sys_data3[1]  = '0;
                w_sys_data3[2]  = '0;
                w_sys_valid3[1] = 1'b0;
                w_sys_valid3[2] = 1'b0;
                if (w_ab && !w_ac) begin
                    w_inc3[2] = 1'b1;
                    w_flt3[2] = 1'b1;
                    w_fault_evt = 1'b1;
                end else if (w_ac && !w_ab) begin
                    w_inc3[1] = 1'b1;
                    w_flt3[1] = 1'b1;
                    w_fault_evt = 1'b1;
                end else if (w_bc && !w_ab) begin
                    w_inc3[0] = 1'b1;
                    w_flt3[0] = 1'b1;
                    w_fault_evt = 1'b1;
                end else if (!w_ab && !w_ac && !w_bc) begin
                    w_fatal_evt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Cores taking part in the current redundancy group
    always_comb begin
        w_part = '0;
        if (r_mode == C_MODE_DMR) begin
            w_part[1:0] = 2'b11;
        end else if (r_mode == C_MODE_TMR) begin
            w_part = '1;
        end
    end

    assign w_part_idle  = &(core_idle_i | ~w_part);
    assign w_mode_legal = (mode_i == C_MODE_IND) || (mode_i == C_MODE_DMR) ||
                          ((mode_i == C_MODE_TMR) && (NumCores == 3));

    assign sys_data_o   = w_sys_data3[NumCores-1:0];
    assign sys_valid_o  = w_sys_valid3[NumCores-1:0];
    assign mode_ready_o = (r_state == ST_RUN) && (&core_idle_i);
    assign mode_o       = r_mode;
    assign halt_o       = r_halt;
    assign resync_o     = r_resync;
    assign fatal_o      = r_fatal;
    assign fault_core_o = r_fault;

    // Recovery FSM with registered halt/resync/fatal and mode register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= ST_RUN;
            r_mode   <= C_MODE_IND;
            r_halt   <= '0;
            r_resync <= '0;
            r_fatal  <= 1'b0;
            r_rcnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_fatal_evt) begin
                        r_state <= ST_FATAL;
                        r_halt  <= w_part;
                        r_fatal <= 1'b1;
                    end else if (w_fault_evt) begin
                        r_state <= ST_DRAIN;
                        r_halt  <= w_part;
                    end
                    if (mode_valid_i && mode_ready_o && w_mode_legal) begin
                        r_mode <= mode_i;
                    end
                end
                ST_DRAIN: begin
                    if (w_part_idle) begin
                        r_state  <= ST_RESYNC;
                        r_resync <= w_part;
                        r_rcnt   <= C_RCW'(ResyncCycles - 1);
                    end
                end
                ST_RESYNC: begin
                    if (r_rcnt == '0) begin
                        r_state  <= ST_RELEASE;
                        r_resync <= '0;
                    end else begin
                        r_rcnt <= r_rcnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_RUN;
                    r_halt  <= '0;
                end
                ST_FATAL: begin
                    if (clear_i) begin
                        r_state <= ST_RUN;
                        r_halt  <= '0;
                        r_fatal <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halt   <= '0;
                    r_resync <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NumCores; gi++) begin : g_cnt
            // Saturating fault counter and sticky fault flag; clear wins
            always_ff @(posedge clk_i) begin
                if (!rst_ni || clear_i) begin
                    err_cnt_o[gi] <= '0;
                    r_fault[gi]   <= 1'b0;
                end else if (r_state == ST_RUN) begin
                    if (w_inc3[gi] && (err_cnt_o[gi] != '1)) begin
                        err_cnt_o[gi] <= err_cnt_o[gi] + 1'b1;
                    end
                    if (w_flt3[gi]) begin
                        r_fault[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hmr_lockstep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hmr_lockstep_ctrl
// Description : Directed self-checking bench for hmr_lockstep_ctrl
//               (3 cores, 16-bit data, 2-bit counters, 4 resync cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hmr_lockstep_ctrl;

    localparam int unsigned NC = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned EW = 2;
    localparam int unsigned RC = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [1:0]             mode_i;
    logic                   mode_valid_i;
    logic                   mode_ready_o;
    logic [1:0]             mode_o;
    logic [NC-1:0][DW-1:0]  core_data_i;
    logic [NC-1:0]          core_valid_i;
    logic [NC-1:0]          core_idle_i;
    logic [NC-1:0][DW-1:0]  sys_data_o;
    logic [NC-1:0]          sys_valid_o;
    logic [NC-1:0]          halt_o;
    logic [NC-1:0]          resync_o;
    logic                   clear_i;
    logic [NC-1:0]          fault_core_o;
    logic [NC-1:0][EW-1:0]  err_cnt_o;
    logic                   fatal_o;

    int n_cmp = 0;
    int n_mis = 0;

    hmr_lockstep_ctrl #(
        .NumCores     (NC),
        .DataWidth    (DW),
        .ErrCntWidth  (EW),
        .ResyncCycles (RC)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .mode_i       (mode_i),
        .mode_valid_i (mode_valid_i),
        .mode_ready_o (mode_ready_o),
        .mode_o       (mode_o),
        .core_data_i  (core_data_i),
        .core_valid_i (core_valid_i),
        .core_idle_i  (core_idle_i),
        .sys_data_o   (sys_data_o),
        .sys_valid_o  (sys_valid_o),
        .halt_o       (halt_o),
        .resync_o     (resync_o),
        .clear_i      (clear_i),
        .fault_core_o (fault_core_o),
        .err_cnt_o    (err_cnt_o),
        .fatal_o      (fatal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cores(input logic [DW-1:0] c0, input logic [DW-1:0] c1, input logic [DW-1:0] c2);
        core_data_i[0] = c0;
        core_data_i[1] = c1;
        core_data_i[2] = c2;
        #1;
    endtask

    initial begin
        rst_ni       = 1'b0;
        mode_i       = 2'd0;
        mode_valid_i = 1'b0;
        clear_i      = 1'b0;
        core_valid_i = 3'b111;
        core_idle_i  = 3'b111;
        set_cores(16'h0, 16'h0, 16'h0);
        tick();
        tick();
        rst_ni = 1'b1;

        // Reset state
        chk("rst_mode", 64'(mode_o), 64'd0);
        chk("rst_halt", 64'(halt_o), 64'd0);
        chk("rst_resync", 64'(resync_o), 64'd0);
        chk("rst_fault", 64'(fault_core_o), 64'd0);
        chk("rst_fatal", 64'(fatal_o), 64'd0);
        chk("rst_errcnt", 64'(err_cnt_o), 64'd0);
        chk("rst_ready", 64'(mode_ready_o), 64'd1);
        core_idle_i = 3'b110;
        #1;
        chk("ready_not_idle", 64'(mode_ready_o), 64'd0);
        core_idle_i = 3'b111;

        // Independent passthrough
        set_cores(16'h000A, 16'h000B, 16'h000C);
        chk("ind_data", 64'(sys_data_o), {16'h0, 16'h000C, 16'h000B, 16'h000A});
        chk("ind_valid", 64'(sys_valid_o), 64'h7);
        tick();
        chk("ind_halt", 64'(halt_o), 64'd0);
        chk("ind_errcnt", 64'(err_cnt_o), 64'd0);

        // Enter DMR
        mode_i = 2'd1;
        mode_valid_i = 1'b1;
        tick();
        mode_valid_i = 1'b0;
        chk("dmr_mode", 64'(mode_o), 64'd1);
        set_cores(16'h0010, 16'h0010, 16'h0033);
        chk("dmr_match_data", 64'(sys_data_o), {16'h0, 16'h0033, 16'h0000, 16'h0010});
        chk("dmr_match_valid", 64'(sys_valid_o), 64'h5);

        // DMR mismatch with cores busy, recovery waits on idle
        core_idle_i = 3'b000;
        set_cores(16'h0010, 16'h0011, 16'h0033);
        chk("dmr_mis_valid", 64'(sys_valid_o), 64'h4);
        tick();
        set_cores(16'h0010, 16'h0010, 16'h0033);
        chk("dmr_errcnt", 64'(err_cnt_o), 64'h05);
        chk("dmr_halt", 64'(halt_o), 64'h3);
        chk("dmr_fault", 64'(fault_core_o), 64'h0);
        mode_i = 2'd2;
        mode_valid_i = 1'b1;
        #1;
        chk("drain_ready", 64'(mode_ready_o), 64'd0);
        set_cores(16'h0010, 16'h0011, 16'h0033);
        tick();
        tick();
        set_cores(16'h0010, 16'h0010, 16'h0033);
        chk("drain_no_count", 64'(err_cnt_o), 64'h05);
        chk("drain_mode_hold", 64'(mode_o), 64'd1);
        chk("drain_halt_wait", 64'(halt_o), 64'h3);
        mode_valid_i = 1'b0;
        core_idle_i = 3'b111;
        tick();
        chk("resync_d1", 64'(resync_o), 64'h3);
        for (int k = 2; k <= RC; k++) begin
            tick();
            chk("resync_dk", 64'(resync_o), 64'h3);
        end
        tick();
        chk("release_resync", 64'(resync_o), 64'h0);
        chk("release_halt", 64'(halt_o), 64'h3);
        tick();
        chk("run_halt", 64'(halt_o), 64'h0);
        chk("run_ready", 64'(mode_ready_o), 64'd1);

        // Four more DMR faults saturate the 2-bit counters
        for (int f = 0; f < 4; f++) begin
            set_cores(16'h0010, 16'h0011, 16'h0033);
            tick();
            set_cores(16'h0010, 16'h0010, 16'h0033);
            repeat (6) tick();
        end
        chk("sat_errcnt", 64'(err_cnt_o), 64'h0F);
        chk("sat_halt", 64'(halt_o), 64'h0);

        // Clear beats a simultaneous increment; recovery still runs
        clear_i = 1'b1;
        set_cores(16'h0010, 16'h0011, 16'h0033);
        tick();
        clear_i = 1'b0;
        set_cores(16'h0010, 16'h0010, 16'h0033);
        chk("clr_errcnt", 64'(err_cnt_o), 64'h00);
        chk("clr_halt", 64'(halt_o), 64'h3);
        repeat (6) tick();
        chk("clr_run_halt", 64'(halt_o), 64'h0);

        // Enter TMR
        mode_i = 2'd2;
        mode_valid_i = 1'b1;
        tick();
        mode_valid_i = 1'b0;
        chk("tmr_mode", 64'(mode_o), 64'd2);

        // TMR single fault on core 2
        set_cores(16'h00FF, 16'h00FF, 16'h000F);
        chk("tmr_vote_data", 64'(sys_data_o), {16'h0, 16'h0000, 16'h0000, 16'h00FF});
        chk("tmr_vote_valid", 64'(sys_valid_o), 64'h1);
        tick();
        set_cores(16'h00FF, 16'h00FF, 16'h00FF);
        chk("tmr_fault", 64'(fault_core_o), 64'h4);
        chk("tmr_errcnt", 64'(err_cnt_o), 64'h10);
        chk("tmr_halt", 64'(halt_o), 64'h7);
        repeat (6) tick();
        chk("tmr_run_halt", 64'(halt_o), 64'h0);

        // TMR three-way disagreement
        set_cores(16'h0001, 16'h0002, 16'h0004);
        chk("fatal_valid", 64'(sys_valid_o), 64'h0);
        tick();
        set_cores(16'h00FF, 16'h00FF, 16'h00FF);
        chk("fatal_flag", 64'(fatal_o), 64'd1);
        chk("fatal_halt", 64'(halt_o), 64'h7);
        repeat (3) tick();
        chk("fatal_sticky", 64'(fatal_o), 64'd1);
        chk("fatal_ready", 64'(mode_ready_o), 64'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("fclr_fatal", 64'(fatal_o), 64'd0);
        chk("fclr_errcnt", 64'(err_cnt_o), 64'h0);
        chk("fclr_fault", 64'(fault_core_o), 64'h0);
        chk("fclr_halt", 64'(halt_o), 64'h0);

        // Reserved mode is accepted but ignored
        mode_i = 2'd3;
        mode_valid_i = 1'b1;
        #1;
        chk("m3_ready", 64'(mode_ready_o), 64'd1);
        tick();
        mode_valid_i = 1'b0;
        chk("m3_mode", 64'(mode_o), 64'd2);

        // Reset in the middle of recovery
        set_cores(16'h00FF, 16'h00FF, 16'h000F);
        tick();
        set_cores(16'h00FF, 16'h00FF, 16'h00FF);
        chk("mid_halt", 64'(halt_o), 64'h7);
        rst_ni = 1'b0;
        tick();
        chk("mid_rst_halt", 64'(halt_o), 64'h0);
        chk("mid_rst_mode", 64'(mode_o), 64'd0);
        chk("mid_rst_errcnt", 64'(err_cnt_o), 64'h0);
        chk("mid_rst_fault", 64'(fault_core_o), 64'h0);
        rst_ni = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
